btn_event_arb: RTL and testbench
================================

BTN_EVENT_ARB -- requirements
Module: btn_event_arb

Interface
REQ-001 Parameter NUM_BTN, default 4, number of debounced button inputs; legal values 2..8.
REQ-002 Parameter FIFO_DEPTH, default 4, event queue entries; power of two, at least 2.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000, hold cycles before the first auto-repeat event.
REQ-004 Parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat events.
REQ-005 Port clk, input, 1, single system clock; all logic on posedge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port clean_btn, input, NUM_BTN, debounced button levels, already synchronous to clk.
REQ-008 Port evt_valid, output, 1, head-of-queue event available.
REQ-009 Port evt_ready, input, 1, consumer accepts the head event.
REQ-010 Port evt_id, output, $clog2(NUM_BTN), index of the head event's button.
REQ-011 Port evt_repeat, output, 1, head event was generated by auto-repeat (always 0 when the feature is off).
REQ-012 Port overflow, output, 1, sticky flag: an event was dropped.
REQ-013 Port overflow_clr, input, 1, synchronous clear of overflow.

Function
REQ-014 Per-button prev register; rising edge = clean_btn[i]=1 at edge k with prev[i]=0.
REQ-015 Rising edge at edge k sets pending[i] at edge k.
REQ-016 Round-robin arbiter: per cycle, grant the first pending index at or after rr_ptr, cyclically; when granted, rr_ptr <= grant+1 mod NUM_BTN.
REQ-017 Grant occurs only when FIFO can accept; the granted button's pending bit clears and {id, repeat} is written in the same edge.
REQ-018 Latency: edge at k -> write at k+1 -> evt_valid=1 in cycle after k+1, with the FIFO previously empty and no competing pending.
REQ-019 FIFO can accept if not full, or if full and evt_valid&&evt_ready in the same cycle (simultaneous push/pop at full is legal).
REQ-020 Pop on evt_valid&&evt_ready; evt_id/evt_repeat stable while evt_valid=1 and evt_ready=0.
REQ-021 New edge while pending[i] is already set and not granted this cycle -> event dropped, overflow <= 1.
REQ-022 FIFO full -> pending bits hold; there is no drop from full alone.
REQ-023 overflow_clr and a new drop in the same cycle -> overflow=1 (set wins).
REQ-024 Falling edges produce no events.

Reset
REQ-025 rst_n=0 immediately forces evt_valid=0, evt_id=0, evt_repeat=0, overflow=0, pending=0, prev=0, rr_ptr=0, FIFO empty, and repeat counters=0.
REQ-026 Reset mid-operation discards all queued and pending events.
REQ-027 A button already held at reset release produces one event, because prev=0.

Configuration
REQ-028 Macro BTN_AUTOREPEAT_EN.
- Defined: a per-button hold counter runs while clean_btn[i]=1.
- The counter reaching REPEAT_DELAY-1, then every REPEAT_PERIOD cycles, sets pending[i] with a repeat tag.
- The counter clears on release.
- A repeat-set hitting an already set pending[i] counts as a drop (REQ-021).
REQ-029 BTN_AUTOREPEAT_EN undefined: no hold counters are synthesised, REPEAT_* are ignored, and evt_repeat is tied 0.

Structure
REQ-030 Package btn_evt_pkg holds:
- NUM_BTN_DEFAULT and FIFO_DEPTH_DEFAULT constants.
- typedef btn_evt_t {id, repeat}, shared with the CPU I/O register block.
REQ-031 Sub-module btn_evt_fifo: synchronous FIFO of btn_evt_t with full/empty and push/pop ports, pointers one bit wider than the address.
REQ-032 The arbiter and edge logic live in btn_event_arb.

Verification
REQ-033 Press btn 2 once, evt_ready=1, FIFO empty -> exactly one event id=2, evt_valid high 2 edges after the first sampled high.
REQ-034 Btns 0,1,3 rise on the same edge, rr_ptr=0 -> events 0,1,3 in order on consecutive cycles, then rr_ptr=0; a following simultaneous 0,3 -> order 0,3.
REQ-035 evt_ready=0, 6 distinct presses of btn 1 spaced 4 cycles, FIFO_DEPTH=4:
- 4 queued, 1 pending.
- 6th press dropped and overflow=1.
- overflow_clr clears it unless another drop occurs in the same cycle.
REQ-036 FIFO full with evt_ready=1 and a pending grant in the same cycle -> pop and push both occur and the count stays 4.
REQ-037 rst_n asserted with 3 queued events and 2 pending -> all outputs 0 immediately; after release with btn 0 held -> a single event id=0.
REQ-038 With BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, btn 1 held 40 cycles -> 1 edge event, then repeat events near hold cycles 20, 25, 30, 35 with evt_repeat=1, none after release.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared button-event types and defaults, also used by the CPU I/O register block.
// Event ids are stored at full width so one struct serves every legal NUM_BTN.
package btn_evt_pkg;

  localparam int NUM_BTN_DEFAULT    = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int EVT_ID_W           = 3;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic                is_repeat;
  } btn_evt_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_event_arb_if.sv
// Event stream handshake: producer holds id/repeat stable while valid is high
// and the consumer has not asserted ready.
interface btn_event_arb_if
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEFAULT
);

  localparam int ID_W = id_w(NUM_BTN);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_repeat,
    output evt_ready
  );

endinterface

// File: rtl/btn_evt_fifo.sv
// Synchronous event queue; push at full is accepted only alongside a pop.
// Head data is combinational from the read pointer and reads zero while empty.
module btn_evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btn_evt_t push_dat,
  input  logic     pop,
  output btn_evt_t pop_dat,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  btn_evt_t    mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // At full the write slot equals the head slot; the head is read out this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/btn_event_arb.sv
// Button rising-edge detector + round-robin arbiter into an event queue; event visible two edges after first high sample.
// Full queue holds pending bits; a second edge on a still-pending button is dropped (sticky overflow). Auto-repeat: BTN_AUTOREPEAT_EN.
module btn_event_arb
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN       = NUM_BTN_DEFAULT,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] clean_btn,
  btn_event_arb_if.master    evt,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam int ID_W = id_w(NUM_BTN);

  logic [NUM_BTN-1:0] prev;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pend_rpt;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] rpt_set;
  logic [NUM_BTN-1:0] set_vec;
  logic [NUM_BTN-1:0] accept_set;
  logic [NUM_BTN-1:0] gnt_vec;
  logic               drop;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      slot;
  logic               gnt_found;
  logic               can_accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  btn_evt_t           push_dat;
  btn_evt_t           head;
  logic               unused_head;

  assign rise    = clean_btn & ~prev;
  assign set_vec = rise | rpt_set;

`ifdef BTN_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0][CNT_W-1:0] hold_cnt;
  logic [NUM_BTN-1:0]            hold_phase;

  // Counter only advances on held cycles after the press edge, so it reads DELAY-1 on hold cycle DELAY.
  always_comb begin
    rpt_set = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_set[i] = clean_btn[i] && prev[i] &&
                   (hold_cnt[i] == (hold_phase[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      hold_phase <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!clean_btn[i]) begin
          hold_cnt[i]   <= '0;
          hold_phase[i] <= 1'b0;
        end else if (rpt_set[i]) begin
          hold_cnt[i]   <= '0;
          hold_phase[i] <= 1'b1;
        end else if (prev[i]) begin
          hold_cnt[i]   <= hold_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rpt_set = '0;
`endif

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    slot      = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      slot = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_BTN)) slot = slot - (ID_W+1)'(NUM_BTN);
      if (!gnt_found && pending[slot[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = slot[ID_W-1:0];
      end
    end
  end

  assign pop        = evt.evt_valid && evt.evt_ready;
  assign can_accept = !full || pop;
  assign push       = gnt_found && can_accept;

  always_comb begin
    gnt_vec = '0;
    if (push) gnt_vec[gnt_idx] = 1'b1;
  end

  // A set landing on a pending bit that is not leaving this cycle is the dropped event.
  assign accept_set = set_vec & ~(pending & ~gnt_vec);
  assign drop       = |(set_vec & pending & ~gnt_vec);

  always_comb begin
    push_dat              = '0;
    push_dat.id[ID_W-1:0] = gnt_idx;
    push_dat.is_repeat    = pend_rpt[gnt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      pending  <= '0;
      pend_rpt <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      prev     <= clean_btn;
      pending  <= (pending & ~gnt_vec) | set_vec;
      pend_rpt <= (accept_set & rpt_set) | (~accept_set & pend_rpt);
      if (push) begin
        rr_ptr <= (gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  assign evt.evt_valid = !empty;
  assign evt.evt_id    = head.id[ID_W-1:0];
`ifdef BTN_AUTOREPEAT_EN
  assign evt.evt_repeat = head.is_repeat;
`else
  assign evt.evt_repeat = 1'b0;
`endif
  assign unused_head = ^head;

endmodule

// File: tb/tb_btn_event_arb.sv
// Directed bench for btn_event_arb: edge capture, round-robin order, overflow, full swap, reset.
module tb_btn_event_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] clean_btn;
  logic       overflow;
  logic       overflow_clr;
  int         total = 0;
  int         bad   = 0;
  int         n;
  int         n_edge;
  int         n_rpt;

  always #5 clk = ~clk;

  btn_event_arb_if #(.NUM_BTN(4)) evt_bus ();

  btn_event_arb #(
    .NUM_BTN       (4),
    .FIFO_DEPTH    (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clean_btn    (clean_btn),
    .evt          (evt_bus),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic tick(input int cycles = 1);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press1();
    clean_btn[1] = 1'b1;
    tick(2);
    clean_btn[1] = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    clean_btn         = '0;
    overflow_clr      = 1'b0;
    evt_bus.evt_ready = 1'b1;
    tick(2);
    check("rst_valid",  evt_bus.evt_valid,  0);
    check("rst_id",     evt_bus.evt_id,     0);
    check("rst_repeat", evt_bus.evt_repeat, 0);
    check("rst_ovf",    overflow,           0);
    rst_n = 1'b1;
    tick(2);

    // Single press of button 2
    clean_btn = 4'b0100;
    tick();
    check("p2_first_edge", evt_bus.evt_valid, 0);
    tick();
    check("p2_valid",  evt_bus.evt_valid,  1);
    check("p2_id",     evt_bus.evt_id,     2);
    check("p2_repeat", evt_bus.evt_repeat, 0);
    tick();
    check("p2_popped", evt_bus.evt_valid, 0);
    tick(3);
    check("p2_held_no_more", evt_bus.evt_valid, 0);
    clean_btn = '0;
    tick(3);
    check("p2_falling_none", evt_bus.evt_valid, 0);

    // Button 3 wraps the round-robin pointer back to 0
    clean_btn = 4'b1000;
    tick(2);
    check("p3_valid", evt_bus.evt_valid, 1);
    check("p3_id",    evt_bus.evt_id,    3);
    clean_btn = '0;
    tick(3);

    // Buttons 0,1,3 together, then 0,3 together
    clean_btn = 4'b1011;
    tick(2);
    check("rr_a_valid", evt_bus.evt_valid, 1);
    check("rr_a_id",    evt_bus.evt_id,    0);
    tick();
    check("rr_b_id", evt_bus.evt_id, 1);
    tick();
    check("rr_c_id", evt_bus.evt_id, 3);
    tick();
    check("rr_end", evt_bus.evt_valid, 0);
    clean_btn = '0;
    tick();
    clean_btn = 4'b1001;
    tick(2);
    check("rr2_a_valid", evt_bus.evt_valid, 1);
    check("rr2_a_id",    evt_bus.evt_id,    0);
    tick();
    check("rr2_b_id", evt_bus.evt_id, 3);
    tick();
    check("rr2_end", evt_bus.evt_valid, 0);
    clean_btn = '0;
    tick(2);

    // Six presses of button 1 with the consumer stalled
    evt_bus.evt_ready = 1'b0;
    for (int p = 0; p < 5; p++) press1();
    check("ov_before",     overflow,          0);
    check("ov_head_valid", evt_bus.evt_valid, 1);
    check("ov_head_id",    evt_bus.evt_id,    1);
    press1();
    check("ov_set", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ov_clr", overflow, 0);
    clean_btn[1] = 1'b1;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ov_set_wins", overflow, 1);
    clean_btn[1] = 1'b0;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ov_clr2", overflow, 0);
    tick();

    // Full queue: pop and pending grant on the same edge, plus a fresh edge on button 1
    clean_btn[1]      = 1'b1;
    evt_bus.evt_ready = 1'b1;
    tick();
    check("swap_no_drop", overflow,          0);
    check("swap_valid",   evt_bus.evt_valid, 1);
    n = 0;
    while (evt_bus.evt_valid && n < 20) begin
      tick();
      n++;
    end
    check("swap_drain_count", n, 5);
    clean_btn = '0;
    tick(2);

    // Reset with 3 queued and 2 pending
    evt_bus.evt_ready = 1'b0;
    clean_btn = 4'b1000;
    tick();
    clean_btn = '0;
    tick();
    clean_btn = 4'b1000;
    tick();
    clean_btn = '0;
    tick();
    clean_btn = 4'b0111;
    tick(2);
    check("pre_rst_valid", evt_bus.evt_valid, 1);
    check("pre_rst_id",    evt_bus.evt_id,    3);
    rst_n = 1'b0;
    #1;
    check("rstm_valid", evt_bus.evt_valid,  0);
    check("rstm_id",    evt_bus.evt_id,     0);
    check("rstm_rpt",   evt_bus.evt_repeat, 0);
    check("rstm_ovf",   overflow,           0);
    clean_btn = 4'b0001;
    tick();
    rst_n             = 1'b1;
    evt_bus.evt_ready = 1'b1;
    tick();
    check("rel_first_edge", evt_bus.evt_valid, 0);
    tick();
    check("rel_valid", evt_bus.evt_valid, 1);
    check("rel_id",    evt_bus.evt_id,    0);
    tick();
    check("rel_popped", evt_bus.evt_valid, 0);
    tick(4);
    check("rel_single", evt_bus.evt_valid, 0);
    clean_btn = '0;
    tick(3);

`ifdef BTN_AUTOREPEAT_EN
    // Hold button 1 for 40 cycles with repeat delay 20, period 5
    n_edge = 0;
    n_rpt  = 0;
    clean_btn[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (evt_bus.evt_valid) begin
        if (evt_bus.evt_repeat) n_rpt++;
        else                    n_edge++;
      end
    end
    clean_btn[1] = 1'b0;
    check("ar_edge_count",   n_edge, 1);
    check("ar_repeat_count", n_rpt,  4);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (evt_bus.evt_valid) n++;
    end
    check("ar_after_release", n, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
